// File: rtl/ti170_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package : ti170_pkg                                                   |
// | Brief   : Shared types and constants for the program loader slice.    |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package ti170_pkg;

  localparam int BYTE_W = 8;

  // Loader FSM states; CHECK is only reachable in the checksum build.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SIZE  = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface : program_loader_if                                         |
// | Brief     : Byte-stream input, memory write port and status of the    |
// |             program loader, bundled for source and loader sides.      |
// | Rev       : 1.0  initial release                                      |
// +-----------------------------------------------------------------------+
interface program_loader_if
  import ti170_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 7
);

  logic                         start;
  logic                         in_valid;
  logic [BYTE_W-1:0]            in_data;
  logic                         in_ready;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [BYTE_W*WORD_BYTES-1:0] mem_wdata;
  logic                         busy;
  logic                         done;
  logic                         error;
  logic [ADDR_W:0]              word_count;

  // Byte source / observer side.
  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
  );

  // Loader side.
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, word_count
  );

endinterface
`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : byte_assembler                                               |
// | Brief  : Packs WORD_BYTES bytes, first byte in the MSBs, into a word  |
// |          and pulses word_full the cycle after the word completes.     |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module byte_assembler
  import ti170_pkg::*;
#(
  parameter int WORD_BYTES = 2
) (
  input  wire logic                         clock,
  input  wire logic                         reset,
  input  wire logic                         clear,
  input  wire logic                         shift_en,
  input  wire logic [BYTE_W-1:0]            byte_in,
  output logic      [BYTE_W*WORD_BYTES-1:0] word,
  output logic                              last_byte,
  output logic                              word_full
);

  localparam int c_WORD_W = BYTE_W * WORD_BYTES;
  localparam int c_IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [c_IDX_W-1:0]  r_idx;
  logic [c_WORD_W-1:0] r_word;
  logic                r_full;
  logic [c_WORD_W-1:0] w_shifted;

  // Shifting left means the first byte of a word ends up in the top byte.
  generate
    if (WORD_BYTES == 1) begin : g_single
      assign w_shifted = byte_in;
    end else begin : g_multi
      assign w_shifted = {r_word[c_WORD_W-BYTE_W-1:0], byte_in};
    end
  endgenerate

  assign last_byte = (r_idx == c_IDX_W'(WORD_BYTES - 1));
  assign word      = r_word;
  assign word_full = r_full;

  // Byte index wraps per word; word_full is not cleared by 'clear' so a
  // final write pulse coinciding with a new start is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx  <= '0;
      r_word <= '0;
      r_full <= 1'b0;
    end else begin
      r_full <= shift_en && last_byte;
      if (clear) begin
        r_idx  <= '0;
        r_word <= '0;
      end else if (shift_en) begin
        r_idx  <= last_byte ? '0 : r_idx + 1'b1;
        r_word <= w_shifted;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : program_loader                                               |
// | Brief  : Consumes a length-prefixed, MSB-first byte stream and writes |
// |          the words into instruction memory before execution starts.   |
// |          Define LOADER_CHECKSUM_EN to require a trailing XOR byte.    |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module program_loader
  import ti170_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 7,
  parameter int MAX_WORDS  = 128
) (
  input  wire logic       clock,
  input  wire logic       reset,
  program_loader_if.slave bus
);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [BYTE_W-1:0] r_size;
  logic [ADDR_W:0]   r_word_count;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_in_ready;
  logic              w_busy;
  logic              w_done;
  logic              w_error;
  logic              w_accept;
  logic              w_clear;
  logic              w_shift;
  logic              w_last_byte;
  logic              w_word_done;
  logic              w_last_word;
  logic              w_word_full;
  logic [BYTE_W*WORD_BYTES-1:0] w_word;

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_clear     = bus.start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_shift     = w_accept && (r_state == DATA);
  assign w_word_done = w_shift && w_last_byte;
  assign w_last_word = w_word_done && ((int'(r_word_count) + 1) == int'(r_size));

  byte_assembler #(
    .WORD_BYTES (WORD_BYTES)
  ) u_asm (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_clear),
    .shift_en  (w_shift),
    .byte_in   (bus.in_data),
    .word      (w_word),
    .last_byte (w_last_byte),
    .word_full (w_word_full)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_xor;

  // Running XOR over the data bytes of the current image.
  always_ff @(posedge clock) begin
    if (reset || w_clear) begin
      r_xor <= '0;
    end else if (w_shift) begin
      r_xor <= r_xor ^ bus.in_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status outputs; the stream is accepted only in loading states.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_error    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = SIZE;
      end
      SIZE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_accept) begin
          if (bus.in_data == '0) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = CHECK;
`else
            w_next = DONE;
`endif
          end else if (int'(bus.in_data) > MAX_WORDS) begin
            w_next = ERR;
          end else begin
            w_next = DATA;
          end
        end
      end
      DATA: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_accept) w_next = (bus.in_data == r_xor) ? DONE : ERR;
      end
`endif
      DONE: begin
        w_done = 1'b1;
        if (bus.start) w_next = SIZE;
      end
      ERR: begin
        w_error = 1'b1;
        if (bus.start) w_next = SIZE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Size capture, word counter and write address; the address is latched as
  // the word completes so it lines up with the write pulse one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_size       <= '0;
      r_word_count <= '0;
      r_mem_addr   <= '0;
    end else begin
      if (w_clear) begin
        r_word_count <= '0;
      end else if (w_word_done) begin
        r_word_count <= r_word_count + 1'b1;
        r_mem_addr   <= r_word_count[ADDR_W-1:0];
      end
      if (w_accept && r_state == SIZE) begin
        r_size <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.error      = w_error;
  assign bus.mem_we     = w_word_full;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = w_word;
  assign bus.word_count = r_word_count;

endmodule
`default_nettype wire
